// File: rtl/pss_generator.sv
// pss_generator: on request, emits the NR primary synchronisation sequence
// d_PSS(n), n=0..126, for the selected N_ID_2 as BPSK samples {im=0, re=+/-AMPLITUDE}
// on an AXI-stream master.
// Optional feature macro PSS_GENERATOR_SSB_PAD_EN: frames the 127 PSS samples
// with 56 leading and 57 trailing zero samples (240-sample SSB symbol).
module pss_generator #(
  parameter int unsigned OUT_DW    = 32,
  parameter int unsigned AMPLITUDE = 8191,
  parameter int unsigned PSS_LEN   = 127
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        n_id_2_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast
);

  localparam int unsigned HALF_W = OUT_DW / 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned M_W    = 7;
`ifdef PSS_GENERATOR_SSB_PAD_EN
  localparam int unsigned PRE_PAD = 56;
  localparam int unsigned TOTAL   = 240;
`else
  localparam int unsigned TOTAL   = PSS_LEN;
`endif
  localparam int unsigned LAST_N = TOTAL - 1;

  localparam logic [HALF_W-1:0] AMP_P = HALF_W'(AMPLITUDE);
  localparam logic [HALF_W-1:0] AMP_N = HALF_W'(0) - AMP_P;
  // Seed {x6..x0}; bit k of the register holds x(i+k), so bit 0 is the current x(m)
  localparam logic [6:0]        SEED  = 7'b1110110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [6:0]            lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [M_W-1:0]        seek_q, seek_d;
  logic [M_W-1:0]        m0;
  logic                  busy_d, err_d, tvalid_d, tlast_d;
  logic [OUT_DW-1:0]     tdata_d;
  logic                  hs;
  logic                  cur_pss, nxt_pss;

  // x(i+7) = x(i+4) XOR x(i): shift toward bit 0, new term enters at bit 6
  assign lfsr_step = {lfsr_q[4] ^ lfsr_q[0], lfsr_q[6:1]};
  assign hs        = m_axis_out_tvalid & m_axis_out_tready;

  // Initial cyclic offset 43*N_ID_2 for the requested cell ID part
  always_comb begin
    m0 = M_W'(0);
    case (n_id_2_i)
      2'd1:    m0 = M_W'(43);
      2'd2:    m0 = M_W'(86);
      default: m0 = M_W'(0);
    endcase
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    n_d     = n_q;
    seek_d  = seek_q;
    err_d   = 1'b0;

`ifdef PSS_GENERATOR_SSB_PAD_EN
    cur_pss = (n_q >= CNT_W'(PRE_PAD)) && (n_q < CNT_W'(PRE_PAD + PSS_LEN));
`else
    cur_pss = 1'b1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (n_id_2_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            lfsr_d = SEED;
            n_d    = CNT_W'(0);
            seek_d = m0;
            state_d = (m0 != M_W'(0)) ? S_SEEK : S_RUN;
          end
        end
      end
      S_SEEK: begin
        lfsr_d = lfsr_step;
        seek_d = seek_q - M_W'(1);
        if (seek_q == M_W'(1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (cur_pss) begin
            lfsr_d = lfsr_step;
          end
          if (n_q == CNT_W'(LAST_N)) begin
            n_d     = CNT_W'(0);
            state_d = S_IDLE;
          end else begin
            n_d = n_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PSS_GENERATOR_SSB_PAD_EN
    nxt_pss = (n_d >= CNT_W'(PRE_PAD)) && (n_d < CNT_W'(PRE_PAD + PSS_LEN));
`else
    nxt_pss = 1'b1;
`endif

    busy_d   = (state_d != S_IDLE);
    tvalid_d = (state_d == S_RUN);
    tlast_d  = tvalid_d && (n_d == CNT_W'(LAST_N));
    tdata_d  = OUT_DW'(0);
    if (tvalid_d && nxt_pss) begin
      tdata_d = {HALF_W'(0), (lfsr_d[0] ? AMP_N : AMP_P)};
    end
  end

  // State, sequence generator and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q           <= S_IDLE;
      lfsr_q            <= SEED;
      n_q               <= CNT_W'(0);
      seek_q            <= M_W'(0);
      busy_o            <= 1'b0;
      err_o             <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tdata  <= OUT_DW'(0);
    end else begin
      state_q           <= state_d;
      lfsr_q            <= lfsr_d;
      n_q               <= n_d;
      seek_q            <= seek_d;
      busy_o            <= busy_d;
      err_o             <= err_d;
      m_axis_out_tvalid <= tvalid_d;
      m_axis_out_tlast  <= tlast_d;
      m_axis_out_tdata  <= tdata_d;
    end
  end

endmodule

// File: tb/tb_pss_generator.sv
// Bench for pss_generator: random-stall stimulus against a sequence model built
// directly from the recurrence x(i+7) = x(i+4) XOR x(i).
module tb_pss_generator;

  localparam int AMP = 8191;
`ifdef PSS_GENERATOR_SSB_PAD_EN
  localparam int PRE   = 56;
  localparam int TOTAL = 240;
`else
  localparam int PRE   = 0;
  localparam int TOTAL = 127;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  n_id_2_i;
  logic        busy_o;
  logic        err_o;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int errors = 0;
  int checks = 0;
  int x_ref [127];
  logic [31:0] got_data [TOTAL];
  logic        got_last [TOTAL];
  logic [31:0] seq0     [127];

  always #5 clk = ~clk;

  pss_generator dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .n_id_2_i          (n_id_2_i),
    .busy_o            (busy_o),
    .err_o             (err_o),
    .m_axis_out_tdata  (tdata),
    .m_axis_out_tvalid (tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (tlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pss_word(input int xbit);
    logic [15:0] re;
    re = (xbit != 0) ? 16'(-AMP) : 16'(AMP);
    return {16'h0000, re};
  endfunction

  function automatic logic [31:0] exp_beat(input int id, input int i);
    int n;
    if (i < PRE || i >= PRE + 127) return 32'h0;
    n = i - PRE;
    return pss_word(x_ref[(n + 43 * id) % 127]);
  endfunction

  // Called at a negedge; drives one request and collects/checks every beat.
  task automatic run_seq(input int id, input bit rnd, input bit spam,
                         input int abort_at, input bit chk_lat);
    int lat;
    int cyc;
    int idx;
    bit stall;
    logic [31:0] pd;
    logic pl;
    start_i  = 1'b1;
    n_id_2_i = 2'(id);
    tready   = rnd ? 1'($urandom % 2) : 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!tvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (chk_lat) check($sformatf("latency_id%0d", id), 32'(lat), 32'(1 + 43 * id));
    if (!tvalid) begin
      check("first_tvalid", 32'(tvalid), 32'd1);
      return;
    end
    check("busy_in_run", 32'(busy_o), 32'd1);
    idx = 0; cyc = 0; stall = 1'b0; pd = '0; pl = 1'b0;
    while (idx < TOTAL && cyc < 20000) begin
      if (idx == abort_at) return;
      if (stall) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_data", tdata, pd);
        check("stall_last", 32'(tlast), 32'(pl));
      end
      if (spam) begin
        check("err_in_run", 32'(err_o), 32'd0);
        start_i  = (idx < TOTAL - 4) ? 1'($urandom % 2) : 1'b0;
        n_id_2_i = 2'($urandom);
      end
      tready = rnd ? 1'($urandom % 2) : 1'b1;
      if (tvalid && tready) begin
        got_data[idx] = tdata;
        got_last[idx] = tlast;
        idx++;
        stall = 1'b0;
      end else begin
        stall = tvalid;
        pd    = tdata;
        pl    = tlast;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check($sformatf("beats_id%0d", id), 32'(idx), 32'(TOTAL));
    check("after_last_valid", 32'(tvalid), 32'd0);
    check("after_last_tlast", 32'(tlast), 32'd0);
    check("after_last_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < idx; i++) begin
      check($sformatf("data_id%0d[%0d]", id, i), got_data[i], exp_beat(id, i));
      check($sformatf("last_id%0d[%0d]", id, i), 32'(got_last[i]), 32'(i == TOTAL - 1));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [9];
    int npos;
    int nneg;
    t1 = '{32'h00001FFF, 32'h0000E001, 32'h0000E001, 32'h00001FFF, 32'h0000E001,
           32'h0000E001, 32'h0000E001, 32'h0000E001, 32'h00001FFF};

    // Reference sequence from the seed x0..x6 = 0,1,1,0,1,1,1
    x_ref[0] = 0; x_ref[1] = 1; x_ref[2] = 1; x_ref[3] = 0;
    x_ref[4] = 1; x_ref[5] = 1; x_ref[6] = 1;
    for (int i = 0; i < 120; i++) x_ref[i + 7] = x_ref[i + 4] ^ x_ref[i];

    reset_i = 1'b1; start_i = 1'b0; n_id_2_i = 2'd0; tready = 1'b0;
    #12;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk);

    // N_ID_2 = 0, full throughput
    run_seq(0, 1'b0, 1'b0, -1, 1'b1);
    for (int k = 0; k < 9; k++) check($sformatf("t1_word[%0d]", k), got_data[PRE + k], t1[k]);
    npos = 0; nneg = 0;
    for (int n = 0; n < 127; n++) begin
      seq0[n] = got_data[PRE + n];
      if (got_data[PRE + n] == 32'h00001FFF) npos++;
      if (got_data[PRE + n] == 32'h0000E001) nneg++;
    end
    check("t1_pos_count", 32'(npos), 32'd63);
    check("t1_neg_count", 32'(nneg), 32'd64);
`ifdef PSS_GENERATOR_SSB_PAD_EN
    check("pad_beat57", got_data[56], 32'h00001FFF);
    check("pad_beat58", got_data[57], 32'h0000E001);
    check("pad_beat1", got_data[0], 32'h0);
    check("pad_beat240", got_data[239], 32'h0);
`endif

    // N_ID_2 = 1 and 2: latency and cyclic shift of the N_ID_2 = 0 sequence
    @(negedge clk);
    run_seq(1, 1'b0, 1'b0, -1, 1'b1);
    for (int n = 0; n < 127; n += 7)
      check($sformatf("shift43[%0d]", n), got_data[PRE + n], seq0[(n + 43) % 127]);
    @(negedge clk);
    run_seq(2, 1'b0, 1'b0, -1, 1'b1);
    for (int n = 0; n < 127; n += 7)
      check($sformatf("shift86[%0d]", n), got_data[PRE + n], seq0[(n + 86) % 127]);

    // Random back-pressure
    @(negedge clk);
    run_seq(2, 1'b1, 1'b0, -1, 1'b1);

    // Invalid N_ID_2
    @(negedge clk);
    start_i = 1'b1; n_id_2_i = 2'd3;
    @(negedge clk);
    start_i = 1'b0;
    check("err_pulse", 32'(err_o), 32'd1);
    check("err_busy", 32'(busy_o), 32'd0);
    check("err_tvalid", 32'(tvalid), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(err_o), 32'd0);
    check("err_busy2", 32'(busy_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("err_no_tvalid", 32'(tvalid), 32'd0);
    end

    // start_i spam during RUN with random stalls
    run_seq(1, 1'b1, 1'b1, -1, 1'b1);

    // Reset mid-RUN at beat 60, then restart and back-to-back requests
    @(negedge clk);
    run_seq(0, 1'b0, 1'b0, 60, 1'b0);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_tlast", 32'(tlast), 32'd0);
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk);
    run_seq(0, 1'b0, 1'b0, -1, 1'b1);
    run_seq(2, 1'b0, 1'b0, -1, 1'b1);
    run_seq(1, 1'b1, 1'b0, -1, 1'b1);

    // Reset mid-SEEK
    @(negedge clk);
    start_i = 1'b1; n_id_2_i = 2'd2;
    @(negedge clk); start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("seekrst_busy", 32'(busy_o), 32'd0);
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk);
    run_seq(2, 1'b1, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pss_generator.md
Name: pss_generator

Overview:
- Transmit-side counterpart of the PSS correlator: on request, generates the NR primary synchronisation sequence d_PSS(n), n=0..126, for a selected N_ID_2.
- Emits it as BPSK-mapped complex samples on an AXI-stream master.
- Feeds the TX resource-grid mapper and serves as the stimulus source for correlator loopback benches.

Parameters:
OUT_DW, 32, output sample width; {im, re}, each OUT_DW/2 bits signed two's complement.
AMPLITUDE, 8191, magnitude of the re component; d=+1 gives +AMPLITUDE, d=-1 gives -AMPLITUDE. Must fit in OUT_DW/2 signed.
PSS_LEN, 127, sequence length; fixed by the standard, not to be overridden.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-high
start_i  in  1  generate request; sampled only in IDLE
n_id_2_i  in  2  cell ID part, sampled with start_i; valid range 0..2
busy_o  out  1  high in every state except IDLE
err_o  out  1  one-cycle pulse when start_i is sampled in IDLE with n_id_2_i==3
m_axis_out_tdata  out  OUT_DW  {im=0, re=±AMPLITUDE}
m_axis_out_tvalid  out  1  sample valid
m_axis_out_tready  in  1  downstream ready
m_axis_out_tlast  out  1  high on the final sample of the sequence

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0; state IDLE; LFSR = 7'b1110110 as {x6..x0} (x0=0, x1=1, x2=1, x3=0, x4=1, x5=1, x6=1); counters 0.
- Sequence definition:
  - x(i+7) = x(i+4) XOR x(i).
  - m = (n + 43*N_ID_2) mod 127.
  - d(n) = 1 - 2*x(m).
  - x=0 → re=+AMPLITUDE; x=1 → re=-AMPLITUDE; im always 0.
- State IDLE:
  - start_i=1 with n_id_2_i<3: latch m0 = 0, 43 or 86; load the LFSR seed; go to SEEK if m0>0, else RUN.
  - start_i=1 with n_id_2_i==3: pulse err_o, stay in IDLE.
- State SEEK: advance the LFSR one step per cycle for m0 cycles; no output. Then go to RUN.
- State RUN:
  - tvalid=1; tdata is mapped from the current x(m).
  - On each handshake (tvalid & tready): advance the LFSR, increment n.
  - tlast=1 while n==126.
  - Handshake at n==126: next cycle tvalid=0, tlast=0, state IDLE.
- Latency: the first tvalid is asserted 1+m0 cycles after the clock edge that samples start_i. That is 1, 44 or 87 cycles.
- AXI rules:
  - tdata and tlast are held stable while tvalid & !tready.
  - tvalid never deasserts before its handshake.
  - tvalid is not combinationally dependent on tready.
  - Full throughput: one sample per cycle when tready is held high.
  - With tready=1 throughout, RUN lasts exactly 127 cycles.
- start_i outside IDLE is ignored, with no err_o. n_id_2_i is ignored except when sampled with start_i.
- The LFSR has period 127, so it needs no wrap handling.
- Back-to-back requests: start_i sampled in the IDLE cycle immediately after tlast is accepted must be honoured.
- Reset mid-RUN or mid-SEEK: outputs clear asynchronously. The next start_i produces a complete sequence from n=0.
- All outputs are registered.

Optional Feature:
Macro: PSS_GENERATOR_SSB_PAD_EN
- Defined:
  - Output is a full 240-subcarrier SSB PSS symbol.
  - 56 zero samples (tdata=0), then the 127 PSS samples, then 57 zero samples.
  - tlast only on the 240th sample.
  - Zero padding uses the same handshake rules.
  - The LFSR advances only during the 127 PSS samples.
  - First-tvalid latency is unchanged: the leading zeros start where the first PSS sample would otherwise be.
- Undefined: exactly 127 samples as above. No extra logic is instantiated.

Test Plan:
1. N_ID_2=0, tready=1 → first tvalid 1 cycle after start. The first 9 tdata are 0x00001FFF, 0x0000E001, 0x0000E001, 0x00001FFF, 0x0000E001, 0x0000E001, 0x0000E001, 0x0000E001, 0x00001FFF. 127 beats total; tlast only on beat 127; 63 beats with re=+8191 and 64 with re=-8191.
2. N_ID_2=1 and N_ID_2=2 → first tvalid after 44 and 87 cycles respectively. All 127 samples match the model d(n) = 1 - 2*x((n+43*N_ID_2) mod 127). Each sequence is a cyclic shift of test 1's by 43 or 86.
3. Random tready (50% duty) with N_ID_2=2 → sequence identical to the tready=1 run; tdata and tlast stable during every stall; exactly 127 handshakes.
4. start_i with n_id_2_i=3 → err_o high for exactly 1 cycle; busy_o stays 0; no tvalid. Asserting start_i repeatedly during RUN → no effect, no err_o.
5. Assert reset_i at beat 60 of an N_ID_2=0 run → tvalid and busy_o drop immediately. A new start produces the test 1 sequence from beat 1. A back-to-back start in the cycle after tlast → second sequence complete and correct.
6. With PSS_GENERATOR_SSB_PAD_EN defined and N_ID_2=0 → 240 beats: beats 1-56 are 0x00000000, beat 57 is 0x00001FFF, beat 58 is 0x0000E001, beats 184-240 are zero, and tlast is high only on beat 240.
